// File: rtl/scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Anode patterns are active-low, digit 0 is the most significant.
package scan_pkg;

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        INIT,
        SHOW,
        GUARD
    } scan_state_e;

    localparam logic [3:0] ANODE_D0  = 4'b0111;
    localparam logic [3:0] ANODE_D1  = 4'b1011;
    localparam logic [3:0] ANODE_D2  = 4'b1101;
    localparam logic [3:0] ANODE_D3  = 4'b1110;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    function automatic logic [3:0] anode_of(input logic [IDX_W-1:0] idx);
        unique case (idx)
            2'd0:    return ANODE_D0;
            2'd1:    return ANODE_D1;
            2'd2:    return ANODE_D2;
            default: return ANODE_D3;
        endcase
    endfunction

    function automatic logic [3:0] nibble_of(
        input logic [15:0]      v,
        input logic [IDX_W-1:0] idx
    );
        unique case (idx)
            2'd0:    return v[15:12];
            2'd1:    return v[11:8];
            2'd2:    return v[7:4];
            default: return v[3:0];
        endcase
    endfunction

    // True when digit idx is a zero ahead of the first non-zero digit.
    function automatic logic lead_zero(
        input logic [15:0]      v,
        input logic [IDX_W-1:0] idx
    );
        unique case (idx)
            2'd0:    return v[15:12] == 4'h0;
            2'd1:    return v[15:8] == 8'h00;
            2'd2:    return v[15:4] == 12'h000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot counter: flags the start of the blanking gap and the slot end.
// Held at zero while disabled and cleared when the first count is loaded.
module slot_timer #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic guard_start_o,
    output logic slot_end_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] GUARD_AT = CW'(REFRESH_DIV - BLANK_CYC - 1);
    localparam logic [CW-1:0] END_AT   = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] slot_cnt_q;
    logic [CW-1:0] slot_cnt_d;

    assign guard_start_o = (BLANK_CYC != 0) && (slot_cnt_q == GUARD_AT);
    assign slot_end_o    = (slot_cnt_q == END_AT);

    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        if (clr_i || !en_i || slot_end_o) begin
            slot_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan with frame-aligned BCD handshake.
// Define SCAN_LZS_EN to blank leading zero digits (digit 3 always lit).
module display_scan_ctrl
    import scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      bcd_in,
    input  logic             bcd_valid,
    output logic             bcd_ready,
    output logic [IDX_W-1:0] countout,
    output logic [3:0]       digit_en_n,
    output logic [3:0]       led_bcd,
    output logic             frame_done
);

    scan_state_e      state_q;
    logic [15:0]      disp_q;
    logic [15:0]      disp_d;
    logic [IDX_W-1:0] countout_q;
    logic [IDX_W-1:0] countout_d;
    logic [3:0]       digit_en_n_q;
    logic [3:0]       anode_d;
    logic [3:0]       led_bcd_q;
    logic [3:0]       nibble_d;
    logic             frame_done_q;

    logic guard_start;
    logic slot_end;
    logic running;
    logic boundary;
    logic advance;

    slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) u_slot_timer (
        .clk           (clk),
        .reset         (reset),
        .en_i          (running),
        .clr_i         (state_q == INIT && bcd_valid),
        .guard_start_o (guard_start),
        .slot_end_o    (slot_end)
    );

    assign running   = (state_q != INIT);
    assign boundary  = running && slot_end && (countout_q == IDX_W'(3));
    assign bcd_ready = (state_q == INIT) || boundary;
    assign advance   = running ? slot_end : bcd_valid;

    always_comb begin
        disp_d     = (bcd_valid && bcd_ready) ? bcd_in : disp_q;
        countout_d = running ? countout_q + 1'b1 : '0;
        nibble_d   = nibble_of(disp_d, countout_d);
`ifdef SCAN_LZS_EN
        anode_d = lead_zero(disp_d, countout_d)
                ? ANODE_OFF
                : anode_of(countout_d);
`else
        anode_d = anode_of(countout_d);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            disp_q       <= 16'h0000;
            countout_q   <= '0;
            digit_en_n_q <= ANODE_OFF;
            led_bcd_q    <= 4'h0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= boundary;
            if (advance) begin
                state_q      <= SHOW;
                disp_q       <= disp_d;
                countout_q   <= countout_d;
                digit_en_n_q <= anode_d;
                led_bcd_q    <= nibble_d;
            end else if (state_q == SHOW && guard_start) begin
                state_q      <= GUARD;
                digit_en_n_q <= ANODE_OFF;
            end
        end
    end

    assign countout   = countout_q;
    assign digit_en_n = digit_en_n_q;
    assign led_bcd    = led_bcd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: one instance with a blanking gap, one without.
// Both share stimulus; their slot boundaries line up since REFRESH_DIV matches.
module tb_display_scan_ctrl;

`ifdef SCAN_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic        bcd_valid;

    logic       rdy_a, rdy_b;
    logic [1:0] cnt_a, cnt_b;
    logic [3:0] an_a, an_b;
    logic [3:0] led_a, led_b;
    logic       fd_a, fd_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (rdy_a),
        .countout   (cnt_a),
        .digit_en_n (an_a),
        .led_bcd    (led_a),
        .frame_done (fd_a)
    );

    display_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYC(0)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (rdy_b),
        .countout   (cnt_b),
        .digit_en_n (an_b),
        .led_bcd    (led_b),
        .frame_done (fd_b)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_anode(input int d);
        logic [3:0] pat [4];
        pat[0] = 4'b0111;
        pat[1] = 4'b1011;
        pat[2] = 4'b1101;
        pat[3] = 4'b1110;
        return pat[d];
    endfunction

    function automatic logic [3:0] exp_nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * (3 - d));
        return s[3:0];
    endfunction

    function automatic bit exp_sup(input logic [15:0] v, input int d);
        if (!LZS || d == 3) return 1'b0;
        for (int k = 0; k <= d; k++) begin
            if (exp_nib(v, k) != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Checks ncyc cycles of a frame showing v; optionally offers nxt from cycle vcyc.
    task automatic frame(input logic [15:0] v, input bit fd_first,
                         input logic [15:0] nxt, input int vcyc,
                         input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int d;
            int p;
            bit sup;
            d   = c / 4;
            p   = c % 4;
            sup = exp_sup(v, d);
            check("an_a", {12'h0, an_a},
                  {12'h0, (p < 3 && !sup) ? exp_anode(d) : 4'hF});
            check("an_b", {12'h0, an_b},
                  {12'h0, sup ? 4'hF : exp_anode(d)});
            check("led_a", {12'h0, led_a}, {12'h0, exp_nib(v, d)});
            check("led_b", {12'h0, led_b}, {12'h0, exp_nib(v, d)});
            check("cnt_a", {14'h0, cnt_a}, 16'(d));
            check("cnt_b", {14'h0, cnt_b}, 16'(d));
            check("rdy_a", {15'h0, rdy_a}, {15'h0, c == 15});
            check("rdy_b", {15'h0, rdy_b}, {15'h0, c == 15});
            check("fd_a", {15'h0, fd_a}, {15'h0, fd_first && c == 0});
            check("fd_b", {15'h0, fd_b}, {15'h0, fd_first && c == 0});
            if (vcyc >= 0 && c == vcyc) begin
                bcd_in    = nxt;
                bcd_valid = 1'b1;
            end
            tick();
        end
        if (vcyc >= 0) bcd_valid = 1'b0;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_an_a"}, {12'h0, an_a}, 16'h000F);
        check({tag, "_an_b"}, {12'h0, an_b}, 16'h000F);
        check({tag, "_led"}, {12'h0, led_a}, 16'h0000);
        check({tag, "_cnt"}, {14'h0, cnt_a}, 16'h0000);
        check({tag, "_rdy"}, {15'h0, rdy_a}, 16'h0001);
        check({tag, "_fd"}, {15'h0, fd_a}, 16'h0000);
    endtask

    initial begin
        reset     = 1'b1;
        bcd_in    = 16'h0000;
        bcd_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        idle_checks("rst");
        tick();
        idle_checks("init");

        bcd_in    = 16'h1234;
        bcd_valid = 1'b1;
        tick();
        bcd_valid = 1'b0;
        frame(16'h1234, 1'b0, 16'h5678, 4, 16);
        frame(16'h5678, 1'b1, 16'h0000, -1, 16);
        frame(16'h5678, 1'b1, 16'h0000, -1, 10);

        reset     = 1'b1;
        bcd_in    = 16'h9999;
        bcd_valid = 1'b1;
        tick();
        reset     = 1'b0;
        bcd_valid = 1'b0;
        idle_checks("midrst");
        for (int i = 0; i < 6; i++) begin
            tick();
            idle_checks("hold");
        end

        bcd_in    = 16'h0045;
        bcd_valid = 1'b1;
        tick();
        bcd_valid = 1'b0;
        frame(16'h0045, 1'b0, 16'h0000, 10, 16);
        frame(16'h0000, 1'b1, 16'h0000, -1, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequences the 4-digit multiplexed 7-segment display of the frequency counter.
- Drives the digit index `countout`, the active-low anode enables and the current BCD nibble.
- Holds a shadow copy of the 16-bit BCD count. New counts are accepted through a valid/ready handshake only at frame boundaries, so a frame never shows a mix of old and new digits.
- Inserts a programmable blanking gap between digits to suppress ghosting.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (constraint: >= 2).
- BLANK_CYC, 1000, cycles at the end of each slot with all anodes off (constraint: 0 <= BLANK_CYC < REFRESH_DIV).

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- bcd_in  in  16  packed BCD count: [15:12] most significant digit, [3:0] least significant digit.
- bcd_valid  in  1  bcd_in is offered; must stay high with bcd_in stable until accepted.
- bcd_ready  out  1  shadow register can load this cycle.
- countout  out  2  index of the digit currently being scanned.
- digit_en_n  out  4  active-low anode enables.
- led_bcd  out  4  nibble for the digit currently enabled.
- frame_done  out  1  one-cycle pulse per completed 4-digit frame.

Behaviour:
- Interface timing: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=INIT, countout=0, digit_en_n=4'b1111, led_bcd=4'h0, frame_done=0.
  - shadow register disp_reg=16'h0000, slot counter slot_cnt=0.
- Outputs countout, digit_en_n, led_bcd and frame_done are registered and change on the same edge as state and countout.
- bcd_ready is combinational from registered state only. It never depends on bcd_valid.
- Acceptance: a transfer occurs on an edge where bcd_valid && bcd_ready; disp_reg <= bcd_in on that edge.
- Digit mapping:
  - countout 0: anodes 4'b0111, nibble disp_reg[15:12].
  - countout 1: anodes 4'b1011, nibble disp_reg[11:8].
  - countout 2: anodes 4'b1101, nibble disp_reg[7:4].
  - countout 3: anodes 4'b1110, nibble disp_reg[3:0].
- FSM states: INIT, SHOW, GUARD.
- INIT:
  - Anodes all off, bcd_ready=1.
  - On bcd_valid: load disp_reg, countout<=0, slot_cnt<=0, go to SHOW.
- SHOW:
  - Anodes per mapping; slot_cnt increments every cycle.
  - At slot_cnt == REFRESH_DIV-BLANK_CYC-1: go to GUARD, anodes go to 4'b1111 on that edge.
  - If BLANK_CYC == 0: GUARD is skipped and the slot-end rule below applies at slot_cnt == REFRESH_DIV-1.
- GUARD:
  - Anodes 4'b1111, led_bcd holds its value, slot_cnt increments.
  - At slot_cnt == REFRESH_DIV-1 (slot end): slot_cnt<=0, countout<=countout+1 (wraps 3 to 0), go to SHOW.
- Frame boundary: the slot-end cycle with countout==3.
  - bcd_ready=1 in that cycle only; bcd_ready=0 in all other SHOW and GUARD cycles.
  - If bcd_valid is high, the load occurs on that edge and digit 0 of the new frame shows the new value.
  - If bcd_valid is low, disp_reg is retained.
  - frame_done=1 for exactly the first cycle of the next frame.
- Frame length: 4*REFRESH_DIV cycles, independent of handshake activity.
- Non-BCD nibbles (A–F) pass through unchanged; downstream segment decoding handles them.
- Reset mid-operation takes effect on the next edge regardless of state. The display blanks immediately and any pending bcd_valid is ignored in that cycle.

Optional Feature:
- Macro: SCAN_LZS_EN (leading-zero suppression).
- Defined:
  - Within a frame, zero nibbles more significant than the first non-zero nibble of disp_reg keep their anode at 1 during their SHOW slot.
  - countout, timing and frame_done are unchanged.
  - Digit 3 is never suppressed, so 16'h0000 displays a single "0".
- Undefined: all four digits are always displayed.

Decomposition:
- Shared package scan_pkg:
  - State enum {INIT, SHOW, GUARD}.
  - Anode pattern constants ANODE_D0..D3 and ANODE_OFF=4'b1111.
  - Digit index width constant.
- Sub-module slot_timer:
  - Parameterised slot_cnt counter.
  - Produces guard_start and slot_end strobes; cleared by reset or by a load in INIT.
- The FSM, shadow register and output registers stay in display_scan_ctrl.

Test Plan:
- Reset with REFRESH_DIV=4, BLANK_CYC=1 -> digit_en_n=1111, led_bcd=0, countout=0, bcd_ready=1, frame_done=0.
- In INIT, pulse bcd_valid with 16'h1234 -> per 4-cycle slot, 3 cycles of 0111/1 then 1 cycle of 1111; then 1011/2, 1101/3, 1110/4; frame is 16 cycles, frame_done pulses at cycle 16.
- Assert bcd_valid=1 with 16'h5678 at cycle 5 and hold it -> bcd_ready stays 0 until the boundary cycle; all digits of the frame show 1234; the next frame shows 5678 starting at digit 0.
- BLANK_CYC=0 -> no 1111 cycles once in SHOW; anodes step 0111->1011->1101->1110 every 4 cycles.
- Assert reset during the countout=2 slot -> next edge returns to INIT, 1111, disp_reg=0; no further scanning until a new bcd_valid.
- Compile with SCAN_LZS_EN:
  - 16'h0045 -> digits 0 and 1 stay 1111 in their slots; digits 2 and 3 show 4 and 5.
  - 16'h0000 -> only digit 3 lights, showing 0.
